// File: rtl/lc3_controller.sv
// lc3_controller: multi-cycle LC-3 subset control FSM with memory-wait timeout.
// Outputs are decoded from the state alone, except ld_mdr in read states, which follows mem_ready.
module lc3_controller #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_ready,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic [1:0]  pc_sel,
  output logic [1:0]  gate_sel,
  output logic [1:0]  alu_ctrl,
  output logic        dr_r7,
  output logic        mem_en,
  output logic        mem_we,
  output logic [4:0]  state,
  output logic        halted,
  output logic        mem_timeout
);
  typedef enum logic [4:0] {
    FETCH0 = 5'd0, FETCH1 = 5'd1, FETCH2 = 5'd2, DECODE = 5'd3,
    ADD0 = 5'd4, AND0 = 5'd5, NOT0 = 5'd6, BR0 = 5'd7, BR1 = 5'd8,
    JSR0 = 5'd9, JSR1 = 5'd10, LD0 = 5'd11, LD1 = 5'd12, LD2 = 5'd13,
    ST0 = 5'd14, ALL_ST0 = 5'd15, ALL_ST1 = 5'd16, STR0 = 5'd17,
    STI0 = 5'd18, STI1 = 5'd19, STI2 = 5'd20, JMP0 = 5'd21, UNKNOWN = 5'd31
  } state_t;
  localparam logic [7:0] LP_LAST = 8'(MEM_WAIT_MAX - 1);
  state_t     r_state, w_next;
  logic [7:0] r_cnt;
  logic       r_mto;
  logic       w_wait, w_timeout, w_taken;
  state_t     w_stay;
  assign w_wait    = (r_state == FETCH1) || (r_state == LD1) || (r_state == ALL_ST1);
  // The cycle that would bring the count to MEM_WAIT_MAX is the last one allowed.
  assign w_timeout = w_wait && !mem_ready && (r_cnt >= LP_LAST);
  assign w_stay    = w_timeout ? UNKNOWN : r_state;
  assign w_taken   = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH0;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
      r_mto <= 1'b0;
    end else begin
      r_cnt <= !w_wait ? 8'd0 : (mem_ready || r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
      if (w_timeout) r_mto <= 1'b1;
    end
  end
  always_comb begin
    w_next = UNKNOWN;
    case (r_state)
      FETCH0:            w_next = FETCH1;
      FETCH1:            w_next = mem_ready ? FETCH2 : w_stay;
      FETCH2:            w_next = DECODE;
      DECODE:
        case (ir[15:12])
          4'b0001: w_next = ADD0;
          4'b0101: w_next = AND0;
          4'b1001: w_next = NOT0;
          4'b0100: w_next = JSR0;
          4'b0000: w_next = BR0;
          4'b0010: w_next = LD0;
          4'b0011: w_next = ST0;
          4'b1100: w_next = JMP0;
          default: w_next = UNKNOWN;
        endcase
      ADD0, AND0, NOT0:  w_next = FETCH0;
      BR0:               w_next = w_taken ? BR1 : FETCH0;
      BR1, JSR1, LD2:    w_next = FETCH0;
      JSR0:              w_next = JSR1;
      LD0:               w_next = LD1;
      LD1:               w_next = mem_ready ? LD2 : w_stay;
      ST0:               w_next = ALL_ST0;
      ALL_ST0:           w_next = ALL_ST1;
      ALL_ST1:           w_next = mem_ready ? FETCH0 : w_stay;
      JMP0:              w_next = FETCH0;
      default:           w_next = UNKNOWN;
    endcase
  end
  always_comb begin
    ld_mar = 1'b0; ld_mdr = 1'b0; ld_ir = 1'b0; ld_pc = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0;
    pc_sel = 2'd0; gate_sel = 2'd0; alu_ctrl = 2'd0; dr_r7 = 1'b0; mem_en = 1'b0; mem_we = 1'b0;
    case (r_state)
      FETCH0:         begin ld_mar = 1'b1; gate_sel = 2'd2; ld_pc = 1'b1; end
      FETCH1, LD1:    begin mem_en = 1'b1; ld_mdr = mem_ready; end
      FETCH2:         begin ld_ir = 1'b1; gate_sel = 2'd1; end
      ADD0:           begin ld_reg = 1'b1; ld_cc = 1'b1; alu_ctrl = 2'd1; end
      AND0:           begin ld_reg = 1'b1; ld_cc = 1'b1; alu_ctrl = 2'd2; end
      NOT0:           begin ld_reg = 1'b1; ld_cc = 1'b1; alu_ctrl = 2'd3; end
      BR1:            begin ld_pc = 1'b1; pc_sel = 2'd1; end
      JSR0:           begin ld_reg = 1'b1; dr_r7 = 1'b1; gate_sel = 2'd2; end
      JSR1:           begin ld_pc = 1'b1; pc_sel = ir[11] ? 2'd2 : 2'd3; end
      LD0, ST0:       begin ld_mar = 1'b1; gate_sel = 2'd3; end
      LD2:            begin ld_reg = 1'b1; ld_cc = 1'b1; gate_sel = 2'd1; end
      ALL_ST0:        ld_mdr = 1'b1;
      ALL_ST1:        begin mem_en = 1'b1; mem_we = 1'b1; end
      JMP0:           begin ld_pc = 1'b1; pc_sel = 2'd3; end
      default:        ;
    endcase
  end
  assign state       = r_state;
  assign halted      = (r_state == UNKNOWN);
  assign mem_timeout = r_mto;
endmodule
